// File: rtl/riscv_imem_if_pkg.sv
// Shared widths and queue-entry types for the instruction-memory interface.
package riscv_imem_if_pkg;

    localparam int XLEN        = 32;
    localparam int PARCEL_SIZE = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            misaligned;
    } imem_tag_t;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [PARCEL_SIZE-1:0] parcel;
        logic                   misaligned;
        logic                   err;
    } imem_parcel_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/riscv_imem_if_if.sv
// Pipelined req/gnt/ack instruction-memory bus; master is the fetch unit.
interface riscv_imem_if_if;
    import riscv_imem_if_pkg::*;

    logic                   imem_req;
    logic [XLEN-1:0]        imem_adr;
    logic                   imem_gnt;
    logic                   imem_ack;
    logic                   imem_err;
    logic [PARCEL_SIZE-1:0] imem_q;

    modport master (
        output imem_req, imem_adr,
        input  imem_gnt, imem_ack, imem_err, imem_q
    );

    modport slave (
        input  imem_req, imem_adr,
        output imem_gnt, imem_ack, imem_err, imem_q
    );

endinterface

// File: rtl/riscv_imem_if_sync_fifo.sv
// Synchronous FIFO of an arbitrary entry type; clear empties it but a same-cycle push still lands.
module riscv_imem_if_sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    input  logic          clear,
    output T              head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, wr_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;
    T              mem_q [DEPTH];

    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign head    = mem_q[rd_q];
    assign do_push = push && (clear || !full);
    assign do_pop  = pop && !empty && !clear;
    assign wr_idx  = clear ? '0 : wr_q;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (clear) begin
            rd_d  = '0;
            wr_d  = do_push ? AW'(1) : '0;
            cnt_d = do_push ? CW'(1) : '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: storage is deliberately not reset; cnt_q alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_idx] <= push_data;
    end

endmodule

// File: rtl/riscv_imem_if.sv
// Fetch front end: issues in-order word fetches, buffers parcels, drops stale returns after flush.
module riscv_imem_if
    import riscv_imem_if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XLEN-1:0]          if_nxt_pc,
    output logic                     if_stall_nxt_pc,
    input  logic                     if_stall,
    input  logic                     if_flush,
    output logic [PARCEL_SIZE-1:0]   if_parcel,
    output logic [XLEN-1:0]          if_parcel_pc,
    output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
    output logic                     if_parcel_misaligned,
    output logic                     if_parcel_page_fault,
    riscv_imem_if_if.master          imem
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 2;

    imem_tag_t    tag_in, tag_head;
    imem_parcel_t par_in, par_head;
    logic         tag_full, tag_empty, par_full, par_empty;
    logic [CW-1:0] tag_count, par_count;

    logic [CW-1:0] drop_q, drop_d, aligned_q, aligned_d, drop_sum;
    logic [OW-1:0] occ;
    logic          can_accept, nxt_mis, accepted, complete, head_valid, par_pop;

    // Credits cover fetches in flight, buffered parcels and returns still to be dropped.
    assign occ        = OW'(tag_count) + OW'(par_count) + OW'(drop_q);
    assign can_accept = !rst && (occ < OW'(DEPTH)) && !tag_full;
    assign nxt_mis    = is_misaligned(if_nxt_pc);

    assign imem.imem_req  = can_accept && !nxt_mis;
    assign imem.imem_adr  = if_nxt_pc;
    assign accepted       = can_accept && (nxt_mis || imem.imem_gnt);
    assign if_stall_nxt_pc = !accepted;

    assign tag_in = '{pc: if_nxt_pc, misaligned: nxt_mis};

    always_comb begin
        drop_sum  = drop_q + aligned_q;
        drop_d    = drop_q;
        complete  = 1'b0;
        aligned_d = aligned_q;
        if (if_flush) begin
            drop_d = drop_sum;
            if (imem.imem_ack && drop_sum != '0) drop_d = drop_sum - CW'(1);
            aligned_d = CW'(accepted && !nxt_mis);
        end else begin
            if (drop_q != '0) begin
                if (imem.imem_ack) drop_d = drop_q - CW'(1);
            end else if (!tag_empty && !par_full && (tag_head.misaligned || imem.imem_ack)) begin
                complete = 1'b1;
            end
            aligned_d = aligned_q + CW'(accepted && !nxt_mis)
                                  - CW'(complete && !tag_head.misaligned);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q    <= '0;
            aligned_q <= '0;
        end else begin
            drop_q    <= drop_d;
            aligned_q <= aligned_d;
        end
    end

    // A misaligned fetch never touched memory, so its data and error bits are forced clean.
    assign par_in = '{pc:         tag_head.pc,
                      parcel:     tag_head.misaligned ? '0 : imem.imem_q,
                      misaligned: tag_head.misaligned,
                      err:        !tag_head.misaligned && imem.imem_err};

    riscv_imem_if_sync_fifo #(.T(imem_tag_t), .DEPTH(DEPTH)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .push      (accepted),
        .push_data (tag_in),
        .pop       (complete),
        .clear     (if_flush),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    riscv_imem_if_sync_fifo #(.T(imem_parcel_t), .DEPTH(DEPTH)) u_parcel_q (
        .clk       (clk),
        .rst       (rst),
        .push      (complete),
        .push_data (par_in),
        .pop       (par_pop),
        .clear     (if_flush),
        .head      (par_head),
        .full      (par_full),
        .empty     (par_empty),
        .count     (par_count)
    );

    assign head_valid = !rst && !par_empty;
    assign par_pop    = head_valid && !if_stall;

    assign if_parcel_valid      = {(PARCEL_SIZE/16){head_valid}};
    assign if_parcel            = head_valid ? par_head.parcel : '0;
    assign if_parcel_pc         = head_valid ? par_head.pc     : '0;
    assign if_parcel_misaligned = head_valid && par_head.misaligned;
    assign if_parcel_page_fault = head_valid && par_head.err;

endmodule

// File: tb/tb_riscv_imem_if.sv
// Directed bench for riscv_imem_if: one-cycle-latency memory responder plus parcel consumer log.
module tb_riscv_imem_if;
    import riscv_imem_if_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [XLEN-1:0]        if_nxt_pc;
    logic                   if_stall_nxt_pc, if_stall, if_flush;
    logic [PARCEL_SIZE-1:0] if_parcel;
    logic [XLEN-1:0]        if_parcel_pc;
    logic [1:0]             if_parcel_valid;
    logic                   if_parcel_misaligned, if_parcel_page_fault;

    riscv_imem_if_if bus ();

    logic        gnt_en = 1'b0, ack_en = 1'b0;
    logic        ack_r = 1'b0, err_r = 1'b0;
    logic [31:0] q_r = '0, err_addr = 32'hFFFF_FFF0;
    logic        bad_req = 1'b0;

    assign bus.imem_gnt = gnt_en;
    assign bus.imem_ack = ack_r;
    assign bus.imem_err = err_r;
    assign bus.imem_q   = q_r;

    riscv_imem_if #(.DEPTH(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .if_nxt_pc            (if_nxt_pc),
        .if_stall_nxt_pc      (if_stall_nxt_pc),
        .if_stall             (if_stall),
        .if_flush             (if_flush),
        .if_parcel            (if_parcel),
        .if_parcel_pc         (if_parcel_pc),
        .if_parcel_valid      (if_parcel_valid),
        .if_parcel_misaligned (if_parcel_misaligned),
        .if_parcel_page_fault (if_parcel_page_fault),
        .imem                 (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        mis;
        logic        err;
        logic [1:0]  vld;
        int          cyc;
    } rec_t;

    rec_t        got[$];
    logic [31:0] pend[$];
    logic [31:0] granted[$];
    int          n_cmp = 0, n_mis = 0, cyc = 0;

    // Memory: a grant at edge N is answered during cycle N+1 while ack_en is high; data = C0DE_<adr[15:0]>.
    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
        end else begin
            if (ack_r) begin
                assert (pend.size() > 0) else $error("FAIL spurious_ack: observed ack with no fetch outstanding");
                if (pend.size() > 0) void'(pend.pop_front());
            end
            if (bus.imem_req && bus.imem_gnt) begin
                pend.push_back(bus.imem_adr);
                granted.push_back(bus.imem_adr);
            end
        end
        #2;
        ack_r = ack_en && !rst && (pend.size() > 0);
        q_r   = (pend.size() > 0) ? {16'hC0DE, pend[0][15:0]} : 32'h0;
        err_r = ack_r && (pend[0] == err_addr);
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst && !if_flush && if_parcel_valid != 2'b00 && !if_stall)
            got.push_back('{if_parcel_pc, if_parcel, if_parcel_misaligned,
                            if_parcel_page_fault, if_parcel_valid, cyc});
        if (bus.imem_req && bus.imem_adr[1:0] != 2'b00) bad_req = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc);
        bit done = 1'b0;
        if_nxt_pc = pc;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = !if_stall_nxt_pc;
            tick();
        end
        check($sformatf("accept_%0h", pc), 64'(done), 64'd1);
    endtask

    task automatic wait_got(input string tag, input int n);
        for (int i = 0; i < 40 && got.size() < n; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        tick();
        check(tag, 64'(got.size()), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        logic [31:0] pc;

        rst = 1'b1; if_nxt_pc = 32'h200; if_stall = 1'b0; if_flush = 1'b0; gnt_en = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("rst_valid",    64'(if_parcel_valid), 64'd0);
        check("rst_stall_pc", 64'(if_stall_nxt_pc), 64'd1);
        check("rst_req",      64'(bus.imem_req), 64'd0);
        check("rst_parcel",   64'(if_parcel), 64'd0);
        check("rst_pc",       64'(if_parcel_pc), 64'd0);
        check("rst_mis",      64'(if_parcel_misaligned), 64'd0);
        check("rst_pf",       64'(if_parcel_page_fault), 64'd0);
        tick();
        rst = 1'b0; gnt_en = 1'b0; ack_en = 1'b1;
        tick();

        // Stream: three back-to-back fetches come out one per cycle.
        got.delete(); gnt_en = 1'b1;
        send(32'h200); send(32'h204); send(32'h208);
        gnt_en = 1'b0;
        wait_got("s1_count", 3);
        check("s1_pc0",   64'(got[0].pc),   64'h200);
        check("s1_pc1",   64'(got[1].pc),   64'h204);
        check("s1_pc2",   64'(got[2].pc),   64'h208);
        check("s1_data0", 64'(got[0].data), 64'hC0DE_0200);
        check("s1_data2", 64'(got[2].data), 64'hC0DE_0208);
        check("s1_vld",   64'(got[0].vld),  64'h3);
        check("s1_gap01", 64'(got[1].cyc - got[0].cyc), 64'd1);
        check("s1_gap12", 64'(got[2].cyc - got[1].cyc), 64'd1);

        // Backpressure: with the core stalled only DEPTH fetches are taken.
        got.delete(); if_stall = 1'b1; gnt_en = 1'b1; acc = 0; pc = 32'h100;
        for (int c = 0; c < 10; c++) begin
            if_nxt_pc = pc;
            @(negedge clk);
            if (!if_stall_nxt_pc) begin
                acc++;
                pc += 32'd4;
            end
            tick();
        end
        check("s2_accepted", 64'(acc), 64'd4);
        @(negedge clk);
        check("s2_stall_pc", 64'(if_stall_nxt_pc), 64'd1);
        check("s2_req",      64'(bus.imem_req), 64'd0);
        tick();
        gnt_en = 1'b0; if_stall = 1'b0;
        wait_got("s2_count", 4);
        check("s2_pc0", 64'(got[0].pc), 64'h100);
        check("s2_pc1", 64'(got[1].pc), 64'h104);
        check("s2_pc2", 64'(got[2].pc), 64'h108);
        check("s2_pc3", 64'(got[3].pc), 64'h10C);

        // Flush with three fetches outstanding; their late acks must vanish.
        got.delete(); ack_en = 1'b0; gnt_en = 1'b1;
        send(32'h500); send(32'h504); send(32'h508);
        if_nxt_pc = 32'h400; if_flush = 1'b1;
        @(negedge clk);
        check("s3_flush_accept", 64'(if_stall_nxt_pc), 64'd0);
        tick();
        if_flush = 1'b0; gnt_en = 1'b0; ack_en = 1'b1;
        @(negedge clk);
        check("s3_empty_after", 64'(if_parcel_valid), 64'd0);
        tick();
        wait_got("s3_count", 1);
        check("s3_pc",   64'(got[0].pc),   64'h400);
        check("s3_data", 64'(got[0].data), 64'hC0DE_0400);

        // Misaligned PC completes in order without touching memory.
        got.delete(); granted.delete(); gnt_en = 1'b1;
        send(32'h1FC); send(32'h202); send(32'h204);
        gnt_en = 1'b0;
        wait_got("s4_count", 3);
        check("s4_pc0",  64'(got[0].pc),  64'h1FC);
        check("s4_pc1",  64'(got[1].pc),  64'h202);
        check("s4_pc2",  64'(got[2].pc),  64'h204);
        check("s4_mis0", 64'(got[0].mis), 64'd0);
        check("s4_mis1", 64'(got[1].mis), 64'd1);
        check("s4_mis2", 64'(got[2].mis), 64'd0);
        check("s4_nreq", 64'(granted.size()), 64'd2);
        check("s4_req0", 64'(granted[0]), 64'h1FC);
        check("s4_req1", 64'(granted[1]), 64'h204);
        check("s4_bad",  64'(bad_req), 64'd0);

        // Bus error flags only the faulting parcel.
        got.delete(); err_addr = 32'h300; gnt_en = 1'b1;
        send(32'h2FC); send(32'h300); send(32'h304);
        gnt_en = 1'b0;
        wait_got("s5_count", 3);
        check("s5_pc1", 64'(got[1].pc),  64'h300);
        check("s5_pf0", 64'(got[0].err), 64'd0);
        check("s5_pf1", 64'(got[1].err), 64'd1);
        check("s5_pf2", 64'(got[2].err), 64'd0);
        check("s5_mis1", 64'(got[1].mis), 64'd0);

        // Reset with two fetches in flight; nothing stale may surface afterwards.
        got.delete(); ack_en = 1'b0; gnt_en = 1'b1;
        send(32'h600); send(32'h604);
        gnt_en = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("s6_valid",    64'(if_parcel_valid), 64'd0);
        check("s6_stall_pc", 64'(if_stall_nxt_pc), 64'd1);
        check("s6_req",      64'(bus.imem_req), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("s6_valid_after", 64'(if_parcel_valid), 64'd0);
        tick();
        ack_en = 1'b1; gnt_en = 1'b1;
        send(32'h700);
        gnt_en = 1'b0;
        wait_got("s6_count", 1);
        check("s6_pc",   64'(got[0].pc),   64'h700);
        check("s6_data", 64'(got[0].data), 64'hC0DE_0700);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
